mem_port_arbiter: RTL and testbench

// Shares one single-ported, variable-latency memory bus between the IF stage
// (instruction fetch, read-only) and the MEM stage (load/store). Sequences each
// bus transaction through a small FSM. Produces if_stall/mem_stall to freeze the

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and load/store.
// Optional IF starvation guard enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_valid,
    output logic                mem_stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wmask,
    input  logic                bus_ready,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        I_REQ,
        I_WAIT,
        D_REQ,
        D_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [MASK_W-1:0]   bus_wmask_q, bus_wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_valid_q, mem_valid_d;
    logic                grant_if, grant_mem;
    logic                force_if;

    assign grant_if  = (state_q == IDLE) && if_req && (!mem_req || force_if);
    assign grant_mem = (state_q == IDLE) && mem_req && !grant_if;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W =
        ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_if = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_mem && !force_if) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = |STARVE_LIMIT;
    assign force_if     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wmask_d = mem_wmask;
                    state_d     = D_REQ;
                end else if (grant_if) begin
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_wmask_d = '0;
                    state_d     = I_REQ;
                end
            end
            // Accept and response in the same cycle completes the transfer at once.
            I_REQ: begin
                if (bus_ready) begin
                    if (bus_rvalid) begin
                        if_rdata_d = bus_rdata;
                        if_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = I_WAIT;
                    end
                end
            end
            I_WAIT: begin
                if (bus_rvalid) begin
                    if_rdata_d = bus_rdata;
                    if_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            D_REQ: begin
                if (bus_ready) begin
                    if (bus_rvalid) begin
                        mem_rdata_d = bus_rdata;
                        mem_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (bus_rvalid) begin
                    mem_rdata_d = bus_rdata;
                    mem_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_req_d = (state_d == I_REQ) || (state_d == D_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_valid = mem_valid_q;

    // Stalls are held low during reset so every output reads 0 while rst is high.
    assign if_stall  = if_req && !if_valid_q && !rst;
    assign mem_stall = mem_req && !mem_valid_q && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by owner and accept status.
    bit          m_active = 0, m_is_mem = 0, m_acc = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_wmask = 0;
    logic        e_if_valid = 0, e_mem_valid = 0;
    logic [31:0] e_if_rdata = 0, e_mem_rdata = 0;
    int          m_run = 0;
    bit          g_if, g_mem, done;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_acc = 0; m_is_mem = 0;
            e_if_valid = 0; e_mem_valid = 0;
            e_if_rdata = 0; e_mem_rdata = 0;
            m_run = 0;
        end else begin
            g_if = 0; g_mem = 0; done = 0;
            e_if_valid = 0; e_mem_valid = 0;
            if (!m_active) begin
                g_if  = if_req && (!mem_req || (GUARD && m_run >= LIMIT));
                g_mem = mem_req && !g_if;
                if (g_mem) begin
                    m_active = 1; m_is_mem = 1; m_acc = 0;
                    m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
                end else if (g_if) begin
                    m_active = 1; m_is_mem = 0; m_acc = 0;
                    m_we = 0; m_addr = if_addr; m_wdata = 0; m_wmask = 0;
                end
            end else if (!m_acc) begin
                if (bus_ready) begin
                    m_acc = 1;
                    done  = bus_rvalid;
                end
            end else begin
                done = bus_rvalid;
            end
            if (done) begin
                m_active = 0;
                if (m_is_mem) begin e_mem_valid = 1; e_mem_rdata = bus_rdata; end
                else          begin e_if_valid  = 1; e_if_rdata  = bus_rdata; end
            end
            if (!if_req || g_if) m_run = 0;
            else if (g_mem)      m_run = m_run + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("bus_req", bus_req, m_active && !m_acc);
            if (m_active && !m_acc) begin
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_we", bus_we, m_we);
                chk("bus_wmask", bus_wmask, m_wmask);
                if (m_we) chk("bus_wdata", bus_wdata, m_wdata);
            end
            chk("if_valid", if_valid, e_if_valid);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("mem_valid", mem_valid, e_mem_valid);
            chk("mem_rdata", mem_rdata, e_mem_rdata);
            chk("if_stall", if_stall, if_req && !e_if_valid && !rst);
            chk("mem_stall", mem_stall, mem_req && !e_mem_valid && !rst);
        end
    end

    logic [31:0] grants[$];
    bit          pend, prev;
    bit          exp_is_if;

    initial begin
        // Reset with every request asserted
        rst = 1; if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 1;
        mem_addr = 32'h2000; mem_wdata = 32'h1234_5678; mem_wmask = 4'hF;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_if_stall", if_stall, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        rst = 0; if_req = 0; mem_req = 0; mem_we = 0; bus_ready = 0; bus_rvalid = 0;
        @(negedge clk);

        // Single fetch, accepted immediately, response two cycles after bus_req
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("t2_bus_req", bus_req, 1'b1);
        chk("t2_bus_addr", bus_addr, 32'h100);
        bus_ready = 1;
        @(negedge clk);
        chk("t2_bus_req_drop", bus_req, 1'b0);
        bus_ready = 0;
        @(negedge clk);
        bus_rvalid = 1; bus_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("t2_if_valid", if_valid, 1'b1);
        chk("t2_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 0; bus_rvalid = 0;
        @(negedge clk);
        chk("t2_if_valid_once", if_valid, 1'b0);

        // Simultaneous requests: load wins, fetch follows
        if_req = 1; if_addr = 32'h104; mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
        @(negedge clk);
        chk("t3_bus_addr_mem", bus_addr, 32'h2000);
        bus_ready = 1;
        @(negedge clk);
        bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("t3_mem_valid", mem_valid, 1'b1);
        chk("t3_if_valid", if_valid, 1'b0);
        chk("t3_mem_rdata", mem_rdata, 32'h1111_2222);
        mem_req = 0; bus_rvalid = 0;
        @(negedge clk);
        chk("t3_bus_addr_if", bus_addr, 32'h104);
        bus_ready = 1;
        @(negedge clk);
        bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("t3_if_rdata", if_rdata, 32'h3333_4444);
        if_req = 0; bus_rvalid = 0;
        @(negedge clk);

        // Store held off by bus_ready for three cycles; inputs change after IDLE
        mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_bus_req", bus_req, 1'b1);
            chk("t4_bus_cmd", {bus_we, bus_wmask, bus_addr, bus_wdata},
                {1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF});
            mem_addr = 32'h44; mem_wdata = 32'h0; mem_wmask = 4'hF;
            bus_ready = (i == 3);
        end
        @(negedge clk);
        bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h0;
        @(negedge clk);
        chk("t4_mem_valid", mem_valid, 1'b1);
        mem_req = 0; mem_we = 0; bus_rvalid = 0;
        @(negedge clk);

        // Reset during D_WAIT; the late response must be dropped
        mem_req = 1; mem_addr = 32'h3000;
        @(negedge clk);
        bus_ready = 1;
        @(negedge clk);
        bus_ready = 0; rst = 1;
        @(negedge clk);
        rst = 0; mem_req = 0; bus_rvalid = 1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t5_mem_valid", mem_valid, 1'b0);
        chk("t5_bus_req", bus_req, 1'b0);
        chk("t5_mem_rdata", mem_rdata, 32'h0);
        bus_rvalid = 0;
        @(negedge clk);
        chk("t5_mem_valid_late", mem_valid, 1'b0);

        // Requester drops fetch request mid-transaction; completion still pulses
        if_req = 1; if_addr = 32'h200;
        @(negedge clk);
        if_req = 0; bus_ready = 1;
        @(negedge clk);
        bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("t7_if_valid", if_valid, 1'b1);
        chk("t7_if_rdata", if_rdata, 32'h0000_0077);
        bus_rvalid = 0;
        @(negedge clk);

        // Both requests held high with a responsive memory: record grant order
        if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
        bus_ready = 1; pend = 0; prev = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_req && !prev) grants.push_back(bus_addr);
            prev = bus_req;
            bus_rvalid = pend;
            bus_rdata = 32'hA000_0000 + i;
            pend = bus_req;
            if (i == 19) begin if_req = 0; mem_req = 0; end
        end
        bus_ready = 0; bus_rvalid = 0;
        @(negedge clk);

        chk("t6_grant_count_ge6", (grants.size() >= 6), 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp_is_if = GUARD && (i == 4);
            if (i < grants.size())
                chk($sformatf("t6_grant%0d", i), grants[i], exp_is_if ? 32'h100 : 32'h2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
